actv_out_reader: RTL and testbench
==================================

// Module: actv_out_reader
// PURPOSE
//  Consumer end of the convolution engine's output handshake (engine req_o/ack_i).
//  When the engine signals "output RAM complete", it reads the output activation BRAM
//  through its port B. It reads in row-major order at 1 word/clk and presents the words
//  on a valid/ready stream towards the PS/DMA path. It then acknowledges the engine.
//  It sits beside the dual-port output BRAM in the conv top level.
// PARAMETERS
//  DataWidth    8    activation word width
//  DataSizeW    28   input map width
//  DataSizeH    28   input map height
//  ConvoWidth   3    kernel width
//  ConvoHeight  3    kernel height
//  NumOut       (DataSizeW-ConvoWidth+1)*(DataSizeH-ConvoHeight+1)   words per frame (676)
//  AddrWidth    $clog2(DataSizeW*DataSizeH)   BRAM address width
//  BaseAddr     0    first BRAM address of the output frame
// PORTS
//  clk_i        in   1          single clock (engine and BRAM port B)
//  reset_i      in   1          async, active-high reset
//  req_i        in   1          engine req_o: frame ready in BRAM (level)
//  ack_o        out  1          to engine ack_i: frame fully streamed
//  ram_en_o     out  1          BRAM read enable, one read per asserted cycle
//  ram_addr_o   out  AddrWidth  BRAM read address
//  ram_data_i   in   DataWidth  BRAM read data, valid 1 clk after ram_en_o
//  m_valid_o    out  1          stream beat valid
//  m_ready_i    in   1          stream sink ready
//  m_data_o     out  DataWidth  stream data
//  m_last_o     out  1          marks beat NumOut-1
//  busy_o       out  1          state != IDLE
//  err_o        out  1          sticky: req_i dropped before ack_o; cleared by reset only
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM=IDLE, read index=0, FIFO empty, nothing in flight.
//  - FSM IDLE -> READ: req_i=1 sampled in IDLE.
//  - FSM READ -> ACK: handshake (m_valid_o & m_ready_i) on beat NumOut-1.
//  - FSM ACK -> IDLE: req_i=0 sampled.
//  - ack_o is registered and asserted exactly while in ACK. A new frame requires a full
//    4-phase cycle: req rises, ack rises, req falls, ack falls.
//  - Reads: in READ, ram_en_o=1 iff issued<NumOut and (fifo_cnt + inflight - pop) < 2,
//    where pop = m_valid_o & m_ready_i. ram_addr_o = BaseAddr + issue index.
//    The issue index increments per issued read.
//  - Returned word is written into a 2-entry FIFO the cycle after issue. The FIFO head
//    drives m_data_o; m_valid_o = FIFO non-empty.
//  - Push and pop in the same cycle are legal, and count is unchanged. The FIFO never
//    overflows by construction (credit rule).
//  - Latency: req_i sampled at edge k gives first m_valid_o after edge k+2. Throughput is
//    1 beat/clk while m_ready_i=1.
//  - Stream rules: m_data_o/m_last_o stable while m_valid_o & !m_ready_i. m_valid_o never
//    drops without a handshake.
//  - m_last_o = m_valid_o & (beat index == NumOut-1). Beat index counts handshakes,
//    0..NumOut-1.
//  - req_i falls during READ: err_o<=1, and the frame still streams to completion.
//    ACK is then held for exactly 1 clk, since req_i is already 0.
//  - req_i stays high in ACK: ack_o holds, and there is no re-read.
//  - Issue and beat indices reset to 0 on IDLE->READ.
//  - Width rules: indices are $clog2(NumOut+1) bits. Address add is AddrWidth bits; no
//    wrap occurs by construction (BaseAddr+NumOut <= 2**AddrWidth, checked by elaboration
//    assertion).
// STRUCTURE
//  - conv_pkg:
//    - typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_ACK} rd_state_e
//    - function conv_out_words(W,H,CW,CH) used for NumOut
//  - Sub-module skid_fifo2: 2-entry register FIFO with push/pop/count/head, reusable by
//    the input loaders.
//  - Remainder: FSM, issue/beat counters, in-flight flag, credit logic.
// TESTING
//  1. Preload mem[i]=i[7:0], m_ready=1, raise req_i.
//     -> 676 beats, data i%256, first valid 2 clk after req sample, m_last on beat 675.
//     -> ack_o=1 the clk after the last beat; drop req -> ack_o=0 next clk, busy_o=0.
//  2. m_ready random 50%.
//     -> all 676 beats in order, no dup/loss; data stable under stall.
//     -> assertion: fifo_cnt+inflight <= 2.
//  3. m_ready=0 for 20 clk after req.
//     -> exactly 2 ram_en_o pulses (addr 0,1); m_data=mem[0] steady.
//     -> release -> stream resumes at 1 beat/clk.
//  4. Assert reset_i async at beat 100.
//     -> all outputs 0 immediately.
//     -> new req cycle restarts at addr BaseAddr, full 676 beats.
//  5. Drop req_i at beat 10.
//     -> err_o=1 sticky, remaining beats delivered, ack_o high exactly 1 clk.
//  6. DataSizeW=DataSizeH=4, BaseAddr=3: two back-to-back 4-phase frames.
//     -> NumOut=4, addrs 3..6 each frame, m_last on 4th beat.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution engine datapath.
package conv_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_ACK} rd_state_e;

  // Number of valid (no-padding) convolution outputs for a WxH map and CWxCH kernel.
  function automatic int conv_out_words(input int w, input int h, input int cw, input int ch);
    return (w - cw + 1) * (h - ch + 1);
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry register FIFO; head is always the oldest word, push and pop may coincide.
module skid_fifo2 #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [Width-1:0] head
);

  logic [Width-1:0] tail;

  // Callers never pop when empty nor push when full, so those cases are not guarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= push_data;
          else               tail <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            head <= tail;
            tail <= push_data;
          end else begin
            head <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/actv_out_reader.sv
// Streams a finished output activation frame from BRAM port B onto a valid/ready
// link, then completes the 4-phase req/ack handshake with the convolution engine.
//
// state   | meaning
// RD_IDLE | waiting for req_i
// RD_READ | issuing BRAM reads and streaming beats
// RD_ACK  | frame streamed, ack_o high until req_i falls
module actv_out_reader
  import conv_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int DataSizeW   = 28,
  parameter int DataSizeH   = 28,
  parameter int ConvoWidth  = 3,
  parameter int ConvoHeight = 3,
  parameter int NumOut      = conv_out_words(DataSizeW, DataSizeH, ConvoWidth, ConvoHeight),
  parameter int AddrWidth   = $clog2(DataSizeW * DataSizeH),
  parameter int BaseAddr    = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req_i,
  output logic                 ack_o,
  output logic                 ram_en_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  input  logic [DataWidth-1:0] ram_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int IdxWidth = $clog2(NumOut + 1);
  localparam logic [IdxWidth-1:0] NumOutIdx = IdxWidth'(NumOut);
  localparam logic [IdxWidth-1:0] LastIdx   = IdxWidth'(NumOut - 1);

  if (BaseAddr + NumOut > (1 << AddrWidth)) begin : g_addr_range
    $error("actv_out_reader: output frame does not fit in the BRAM address space");
  end

  rd_state_e           state;
  logic [IdxWidth-1:0] issue_idx;
  logic [IdxWidth-1:0] beat_idx;
  logic                inflight;
  logic [1:0]          fifo_cnt;
  logic                pop;
  logic                rd_en;
  logic [2:0]          occupancy;

  assign pop       = m_valid_o & m_ready_i;
  assign m_valid_o = (fifo_cnt != 2'd0);

  // Credit: a read is only issued if its word is guaranteed a FIFO slot next cycle.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en     = (state == RD_READ) && (issue_idx < NumOutIdx) && (occupancy < 3'd2);

  assign ram_en_o   = rd_en;
  assign ram_addr_o = rd_en ? (AddrWidth'(BaseAddr) + AddrWidth'(issue_idx)) : '0;
  assign m_last_o   = m_valid_o && (beat_idx == LastIdx);
  assign busy_o     = (state != RD_IDLE);

  skid_fifo2 #(.Width(DataWidth)) u_fifo (
    .clk       (clk_i),
    .rst       (reset_i),
    .push      (inflight),
    .push_data (ram_data_i),
    .pop       (pop),
    .count     (fifo_cnt),
    .head      (m_data_o)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= RD_IDLE;
      issue_idx <= '0;
      beat_idx  <= '0;
      inflight  <= 1'b0;
      ack_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) issue_idx <= issue_idx + 1'b1;
      if (pop)   beat_idx  <= beat_idx + 1'b1;

      case (state)
        RD_IDLE: begin
          if (req_i) begin
            state     <= RD_READ;
            issue_idx <= '0;
            beat_idx  <= '0;
          end
        end
        RD_READ: begin
          // Engine withdrew the request early: flag it but finish the frame anyway.
          if (!req_i) err_o <= 1'b1;
          if (pop && (beat_idx == LastIdx)) begin
            state <= RD_ACK;
            ack_o <= 1'b1;
          end
        end
        RD_ACK: begin
          if (!req_i) begin
            state <= RD_IDLE;
            ack_o <= 1'b0;
          end
        end
        default: begin
          state <= RD_IDLE;
          ack_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_actv_out_reader.sv
// Directed bench for actv_out_reader: full frames, stalls, async reset, early req drop,
// and a small 4x4 instance with a non-zero base address.
module tb_actv_out_reader;

  localparam int NumOut = 676;
  localparam int N2     = 4;
  localparam int Base2  = 3;

  logic        clk;
  logic        reset_i;
  logic        req, ack, ram_en, m_valid, m_ready, m_last, busy, err;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_data, m_data;
  logic        req2, ack2, ram_en2, m_valid2, m_ready2, m_last2, busy2, err2;
  logic [3:0]  ram_addr2;
  logic [7:0]  ram_data2, m_data2;

  logic [7:0]  mem  [1024];
  logic [7:0]  mem2 [16];

  int checks = 0;
  int errors = 0;

  actv_out_reader dut (
    .clk_i(clk), .reset_i(reset_i), .req_i(req), .ack_o(ack),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_data_i(ram_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .busy_o(busy), .err_o(err)
  );

  actv_out_reader #(.DataSizeW(4), .DataSizeH(4), .BaseAddr(Base2)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .req_i(req2), .ack_o(ack2),
    .ram_en_o(ram_en2), .ram_addr_o(ram_addr2), .ram_data_i(ram_data2),
    .m_valid_o(m_valid2), .m_ready_i(m_ready2), .m_data_o(m_data2), .m_last_o(m_last2),
    .busy_o(busy2), .err_o(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_en)  ram_data  <= mem[ram_addr];
    if (ram_en2) ram_data2 <= mem2[ram_addr2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready driver: 0 = held low, 1 = held high, 2 = random 50%.
  int rdy_mode = 1;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor for the full-size instance.
  int         beat_cnt = 0;
  int         en_cnt   = 0;
  bit         mon_en   = 0;
  bit         stall_prev = 0;
  logic [7:0] held_d;
  logic       held_l;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("credit", 32'((int'(dut.fifo_cnt) + int'(dut.inflight)) <= 2), 32'd1);
        if (ram_en) begin
          chk("addr", 32'(ram_addr), 32'(en_cnt));
          en_cnt++;
        end
        if (stall_prev) begin
          chk("hold_valid", 32'(m_valid), 32'd1);
          chk("hold_data", 32'(m_data), 32'(held_d));
          chk("hold_last", 32'(m_last), 32'(held_l));
        end
        if (m_valid) begin
          if (m_ready) begin
            chk("overrun", 32'(beat_cnt < NumOut), 32'd1);
            chk("data", 32'(m_data), 32'(beat_cnt % 256));
            chk("last", 32'(m_last), 32'(beat_cnt == NumOut - 1));
            beat_cnt++;
            stall_prev = 0;
          end else begin
            stall_prev = 1;
            held_d = m_data;
            held_l = m_last;
          end
        end else begin
          chk("last_idle", 32'(m_last), 32'd0);
          stall_prev = 0;
        end
      end
    end
  end

  // Monitor for the 4x4 instance.
  int beat2 = 0;
  int en2   = 0;
  bit mon2_en = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon2_en) begin
        if (ram_en2) begin
          chk("addr2", 32'(ram_addr2), 32'(Base2 + en2));
          en2++;
        end
        if (m_valid2 && m_ready2) begin
          chk("overrun2", 32'(beat2 < N2), 32'd1);
          chk("data2", 32'(m_data2), 32'(mem2[Base2 + beat2]));
          chk("last2", 32'(m_last2), 32'(beat2 == N2 - 1));
          beat2++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic start_mon();
    beat_cnt   = 0;
    en_cnt     = 0;
    stall_prev = 0;
    mon_en     = 1;
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n = 0;
    while (beat_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (beat_cnt < target) chk(tag, 32'(beat_cnt), 32'(target));
  endtask

  task automatic do_reset();
    mon_en   = 0;
    mon2_en  = 0;
    req      = 1'b0;
    req2     = 1'b0;
    rdy_mode = 1;
    reset_i  = 1'b1;
    repeat (2) tick();
    reset_i  = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i[7:0];
    for (int i = 0; i < 16; i++) mem2[i] = 8'(i * 7 + 8'h41);
    reset_i  = 1'b1;
    req      = 1'b0;
    req2     = 1'b0;
    m_ready2 = 1'b1;
    do_reset();
    chk("reset_outs", {8'd0, ack, ram_en, ram_addr, m_valid, m_data, m_last, busy, err}, 32'd0);

    // 1: full frame, ready always high, latency and handshake timing
    start_mon();
    req = 1'b1;
    tick();
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_k0", 32'(m_valid), 32'd0);
    tick();
    chk("t1_valid_k1", 32'(m_valid), 32'd0);
    tick();
    chk("t1_valid_k2", 32'(m_valid), 32'd1);
    chk("t1_first_data", 32'(m_data), 32'd0);
    wait_beats(NumOut, 800, "t1_timeout");
    chk("t1_ack", 32'(ack), 32'd1);
    chk("t1_reads", 32'(en_cnt), 32'(NumOut));
    repeat (3) tick();
    chk("t1_ack_hold", 32'(ack), 32'd1);
    chk("t1_no_reread", 32'(en_cnt), 32'(NumOut));
    chk("t1_beats", 32'(beat_cnt), 32'(NumOut));
    req = 1'b0;
    tick();
    chk("t1_ack_drop", 32'(ack), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_err", 32'(err), 32'd0);

    // 2: random backpressure
    rdy_mode = 2;
    start_mon();
    req = 1'b1;
    wait_beats(NumOut, 5000, "t2_timeout");
    chk("t2_ack", 32'(ack), 32'd1);
    chk("t2_reads", 32'(en_cnt), 32'(NumOut));
    req = 1'b0;
    tick();
    chk("t2_ack_drop", 32'(ack), 32'd0);
    rdy_mode = 1;
    tick();

    // 3: sink stalled for 20 clk, then released
    rdy_mode = 0;
    start_mon();
    req = 1'b1;
    repeat (20) tick();
    chk("t3_reads", 32'(en_cnt), 32'd2);
    chk("t3_valid", 32'(m_valid), 32'd1);
    chk("t3_data", 32'(m_data), 32'd0);
    chk("t3_no_beats", 32'(beat_cnt), 32'd0);
    rdy_mode = 1;
    begin
      int b0;
      b0 = beat_cnt;
      repeat (10) tick();
      chk("t3_throughput", 32'(beat_cnt - b0), 32'd10);
    end
    wait_beats(NumOut, 800, "t3_timeout");
    chk("t3_ack", 32'(ack), 32'd1);
    req = 1'b0;
    tick();
    chk("t3_ack_drop", 32'(ack), 32'd0);

    // 4: async reset mid-frame, then a clean restart
    start_mon();
    req = 1'b1;
    wait_beats(100, 300, "t4_timeout_a");
    mon_en = 0;
    #3;
    reset_i = 1'b1;
    #1;
    chk("t4_async_reset", {8'd0, ack, ram_en, ram_addr, m_valid, m_data, m_last, busy, err}, 32'd0);
    req = 1'b0;
    repeat (2) tick();
    reset_i = 1'b0;
    tick();
    start_mon();
    req = 1'b1;
    wait_beats(NumOut, 800, "t4_timeout_b");
    chk("t4_ack", 32'(ack), 32'd1);
    chk("t4_reads", 32'(en_cnt), 32'(NumOut));
    req = 1'b0;
    tick();
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: req withdrawn at beat 10
    start_mon();
    req = 1'b1;
    wait_beats(10, 100, "t5_timeout_a");
    req = 1'b0;
    tick();
    chk("t5_err_set", 32'(err), 32'd1);
    wait_beats(NumOut, 800, "t5_timeout_b");
    chk("t5_ack_pulse", 32'(ack), 32'd1);
    chk("t5_beats", 32'(beat_cnt), 32'(NumOut));
    tick();
    chk("t5_ack_one_clk", 32'(ack), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("t5_err_cleared", 32'(err), 32'd0);

    // 6: 4x4 map at base 3, two back-to-back frames
    for (int f = 0; f < 2; f++) begin
      int n;
      beat2   = 0;
      en2     = 0;
      mon2_en = 1;
      req2    = 1'b1;
      n = 0;
      while (beat2 < N2 && n < 20) begin
        tick();
        n++;
      end
      if (beat2 < N2) chk("t6_timeout", 32'(beat2), 32'(N2));
      chk("t6_ack", 32'(ack2), 32'd1);
      chk("t6_reads", 32'(en2), 32'(N2));
      req2 = 1'b0;
      tick();
      chk("t6_ack_drop", 32'(ack2), 32'd0);
      chk("t6_idle", 32'(busy2), 32'd0);
    end
    mon2_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
